// File: rtl/pipe_adder_flags_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// status flag layout and small decode helpers.
package pipe_adder_flags_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  localparam int FLAGS_W = 5;
  localparam int FLG_S   = 4;
  localparam int FLG_Z   = 3;
  localparam int FLG_C   = 2;
  localparam int FLG_P   = 1;
  localparam int FLG_V   = 0;

  function automatic logic op_is_sub(op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Subtraction is x + ~y + 1, so SUB forces the carry-in and SBB inverts the borrow.
  function automatic logic entry_cin(op_e op, logic cin);
    logic r;
    case (op)
      OP_ADD:  r = 1'b0;
      OP_SUB:  r = 1'b1;
      OP_ADC:  r = cin;
      default: r = ~cin;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_adder_flags_if.sv
// Operand/result bus of the add/subtract unit; the unit is the slave,
// the operand fetch and writeback side together form the master.
interface pipe_adder_flags_if #(
  parameter int WIDTH = 16
);
  import pipe_adder_flags_pkg::*;

  // Both sides: a transfer happens on a rising edge where valid & ready are high;
  // the producer holds valid and its payload steady until that edge.
  logic                 in_valid;
  logic                 in_ready;
  op_e                  in_op;
  logic                 in_cin;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_z;
  logic [FLAGS_W-1:0]   out_flags;

  modport master (
    output in_valid, in_op, in_cin, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_z, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_cin, in_x, in_y, out_ready,
    output in_ready, out_valid, out_z, out_flags
  );

endinterface

// File: rtl/pipe_adder_flags_adder_blk.sv
// One ripple block of the pipelined adder: {cout, s} = a + b + cin.
module adder_blk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_adder_flags.sv
// Pipelined N-bit add/subtract with S/Z/C/P/V flags; the carry crosses one
// BLK_W-bit block per clock, and the whole pipe stalls on output backpressure.
module pipe_adder_flags
  import pipe_adder_flags_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_adder_flags_if.slave bus
);

  localparam int NBLK = WIDTH / BLK_W;

  // Register 0 captures the operands at accept; register k+1 holds the result of
  // block k, and register NBLK is the output register with the flags.
  logic [NBLK:0]      v_q, v_d;
  op_e                op_q [NBLK];
  op_e                op_d [NBLK];
  logic [WIDTH-1:0]   x_q  [NBLK];
  logic [WIDTH-1:0]   x_d  [NBLK];
  logic [WIDTH-1:0]   y_q  [NBLK];
  logic [WIDTH-1:0]   y_d  [NBLK];
  logic [NBLK-1:0]    c_q, c_d;
  logic [WIDTH-1:0]   z_q  [1:NBLK];
  logic [WIDTH-1:0]   z_d  [1:NBLK];
  logic [FLAGS_W-1:0] flags_q, flags_d;

  logic [BLK_W-1:0]   blk_s [NBLK];
  logic [NBLK-1:0]    blk_c;
  logic               adv;
  logic [WIDTH-1:0]   z_res;
  logic               xm, ym, zm;

  assign adv           = ~v_q[NBLK] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NBLK];
  assign bus.out_z     = z_q[NBLK];
  assign bus.out_flags = flags_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    adder_blk #(.W(BLK_W)) u_blk (
      .a_i    (x_q[k][k*BLK_W +: BLK_W]),
      .b_i    (y_q[k][k*BLK_W +: BLK_W]),
      .cin_i  (c_q[k]),
      .s_o    (blk_s[k]),
      .cout_o (blk_c[k])
    );
  end

  always_comb begin
    v_d[0]  = bus.in_valid;
    op_d[0] = bus.in_op;
    x_d[0]  = bus.in_x;
    y_d[0]  = op_is_sub(bus.in_op) ? ~bus.in_y : bus.in_y;
    c_d[0]  = entry_cin(bus.in_op, bus.in_cin);
    for (int k = 1; k < NBLK; k++) begin
      v_d[k]  = v_q[k-1];
      op_d[k] = op_q[k-1];
      x_d[k]  = x_q[k-1];
      y_d[k]  = y_q[k-1];
      c_d[k]  = blk_c[k-1];
    end
    v_d[NBLK] = v_q[NBLK-1];
    z_d[1]            = '0;
    z_d[1][BLK_W-1:0] = blk_s[0];
    for (int k = 2; k <= NBLK; k++) begin
      z_d[k]                        = z_q[k-1];
      z_d[k][(k-1)*BLK_W +: BLK_W]  = blk_s[k-1];
    end
  end

  // Flags come from the assembled result leaving the last block; ym is already
  // inverted for SUB/SBB because Y was inverted at entry.
  assign z_res = z_d[NBLK];
  assign xm    = x_q[NBLK-1][WIDTH-1];
  assign ym    = y_q[NBLK-1][WIDTH-1];
  assign zm    = z_res[WIDTH-1];

  always_comb begin
    flags_d        = '0;
    flags_d[FLG_S] = zm;
    flags_d[FLG_Z] = ~|z_res;
    flags_d[FLG_C] = op_is_sub(op_q[NBLK-1]) ? ~blk_c[NBLK-1] : blk_c[NBLK-1];
    flags_d[FLG_P] = ~^z_res;
    flags_d[FLG_V] = (xm & ym & ~zm) | (~xm & ~ym & zm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      for (int k = 0; k < NBLK; k++) begin
        op_q[k] <= OP_ADD;
        x_q[k]  <= '0;
        y_q[k]  <= '0;
      end
      for (int k = 1; k <= NBLK; k++) begin
        z_q[k] <= '0;
      end
    end else if (adv) begin
      v_q     <= v_d;
      c_q     <= c_d;
      flags_q <= flags_d;
      for (int k = 0; k < NBLK; k++) begin
        op_q[k] <= op_d[k];
        x_q[k]  <= x_d[k];
        y_q[k]  <= y_d[k];
      end
      for (int k = 1; k <= NBLK; k++) begin
        z_q[k] <= z_d[k];
      end
    end
  end

endmodule
